// File: rtl/riscv_soft_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port (ALU vs load).
// Optional busy scoreboard is compiled in when RISCV_SOFT_WB_SCOREBOARD_EN is defined.
module riscv_soft_wb_arbiter #(
  parameter int XPR_LEN  = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  input  logic [ADDR_W-1:0]  alu_addr,
  input  logic [XPR_LEN-1:0] alu_data,
  output logic               alu_ready,
  input  logic               ld_valid,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [XPR_LEN-1:0] ld_data,
  output logic               ld_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [XPR_LEN-1:0] wr_data,
  input  logic               sb_set,
  input  logic [ADDR_W-1:0]  sb_set_addr,
  input  logic [ADDR_W-1:0]  sb_query_addr_1,
  input  logic [ADDR_W-1:0]  sb_query_addr_2,
  output logic               sb_busy_1,
  output logic               sb_busy_2
);

  localparam logic              LG_ALU    = 1'b0;
  localparam logic              LG_LD     = 1'b1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic               last_grant_q;
  logic               last_grant_d;
  logic               wr_en_q;
  logic               wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [XPR_LEN-1:0] wr_data_q;
  logic [XPR_LEN-1:0] wr_data_d;
  logic               alu_grant_s;
  logic               ld_grant_s;

  // On a tie the port that did not win last time gets the grant; nothing is granted in reset.
  always_comb begin
    alu_grant_s = 1'b0;
    ld_grant_s  = 1'b0;
    if (reset) begin
      alu_grant_s = 1'b0;
      ld_grant_s  = 1'b0;
    end else if (alu_valid && ld_valid) begin
      alu_grant_s = (last_grant_q == LG_LD);
      ld_grant_s  = (last_grant_q == LG_ALU);
    end else begin
      alu_grant_s = alu_valid;
      ld_grant_s  = ld_valid;
    end
  end

  assign alu_ready = alu_grant_s;
  assign ld_ready  = ld_grant_s;

  // x0 writes are consumed and advance round-robin, but never raise wr_en; address/data hold.
  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (alu_grant_s) begin
      last_grant_d = LG_ALU;
      if (alu_addr != ZERO_ADDR) begin
        wr_en_d   = 1'b1;
        wr_addr_d = alu_addr;
        wr_data_d = alu_data;
      end else begin
        wr_en_d = 1'b0;
      end
    end else if (ld_grant_s) begin
      last_grant_d = LG_LD;
      if (ld_addr != ZERO_ADDR) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ld_addr;
        wr_data_d = ld_data;
      end else begin
        wr_en_d = 1'b0;
      end
    end else begin
      last_grant_d = last_grant_q;
      wr_en_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= LG_LD;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= {XPR_LEN{1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                sb_busy_1_s;
  logic                sb_busy_2_s;

  // A new producer issued on the same edge as the old write retiring keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (sb_set && (sb_set_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en_q && (wr_addr_q == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    sb_busy_1_s = 1'b0;
    sb_busy_2_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sb_query_addr_1 == ADDR_W'(i)) begin
        sb_busy_1_s = busy_q[i];
      end else begin
        sb_busy_1_s = sb_busy_1_s;
      end
      if (sb_query_addr_2 == ADDR_W'(i)) begin
        sb_busy_2_s = busy_q[i];
      end else begin
        sb_busy_2_s = sb_busy_2_s;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign sb_busy_1 = sb_busy_1_s;
  assign sb_busy_2 = sb_busy_2_s;
`else
  logic unused_sb_s;
  assign unused_sb_s = ^{sb_set, sb_set_addr, sb_query_addr_1, sb_query_addr_2};
  assign sb_busy_1   = 1'b0;
  assign sb_busy_2   = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_soft_wb_arbiter.sv
// Bench for riscv_soft_wb_arbiter: vector table, hand sequences for reset and scoreboard,
// then random traffic against a rule-level reference model.
module tb_riscv_soft_wb_arbiter;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;
`ifdef RISCV_SOFT_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid, alu_ready, ld_ready;
  logic [AW-1:0] alu_addr, ld_addr;
  logic [XL-1:0] alu_data, ld_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [XL-1:0] wr_data;
  logic          sb_set, sb_busy_1, sb_busy_2;
  logic [AW-1:0] sb_set_addr, sb_query_addr_1, sb_query_addr_2;

  riscv_soft_wb_arbiter #(.XPR_LEN(XL), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .sb_query_addr_1(sb_query_addr_1), .sb_query_addr_2(sb_query_addr_2),
    .sb_busy_1(sb_busy_1), .sb_busy_2(sb_busy_2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who won last, what the register file will see, which regs are pending.
  bit            m_ld_last;
  bit            m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [XL-1:0] m_wr_data;
  bit            m_busy [NR];

  typedef struct {
    bit            av;
    logic [AW-1:0] aa;
    logic [XL-1:0] ad;
    bit            lv;
    logic [AW-1:0] la;
    logic [XL-1:0] ld;
    bit            e_ar;
    bit            e_lr;
    bit            e_we;
    logic [AW-1:0] e_wa;
    logic [XL-1:0] e_wd;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ld_last = 1'b1;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    sb_set = 1'b0; sb_set_addr = '0; sb_query_addr_1 = '0; sb_query_addr_2 = '0;
  endtask

  // One cycle: drive after the falling edge, check, then advance the model past the rising edge.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [XL-1:0] ad,
                      input bit lv, input logic [AW-1:0] la, input logic [XL-1:0] ld,
                      input bit ss, input logic [AW-1:0] sa,
                      input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    bit e_ar, e_lr, e_b1, e_b2;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ld;
    sb_set = ss; sb_set_addr = sa; sb_query_addr_1 = q1; sb_query_addr_2 = q2;
    #1;
    if (av && lv) begin
      e_ar = m_ld_last;
      e_lr = !m_ld_last;
    end else begin
      e_ar = av;
      e_lr = lv;
    end
    e_b1 = SB ? m_busy[q1] : 1'b0;
    e_b2 = SB ? m_busy[q2] : 1'b0;
    chk("m_alu_ready", 64'(alu_ready), 64'(e_ar));
    chk("m_ld_ready", 64'(ld_ready), 64'(e_lr));
    chk("m_wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("m_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    chk("m_wr_data", 64'(wr_data), 64'(m_wr_data));
    chk("m_sb_busy_1", 64'(sb_busy_1), 64'(e_b1));
    chk("m_sb_busy_2", 64'(sb_busy_2), 64'(e_b2));
    if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
    if (ss && sa != 0) m_busy[sa] = 1'b1;
    if (e_ar || e_lr) begin
      m_ld_last = e_lr;
      m_wr_en   = e_ar ? (aa != 0) : (la != 0);
      if (m_wr_en) begin
        m_wr_addr = e_ar ? aa : la;
        m_wr_data = e_ar ? ad : ld;
      end
    end else begin
      m_wr_en = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    // Expected outputs in each row are the registered results of the previous row.
    vecs[0]  = '{1, 5'd1, 32'h0000_00A1, 1, 5'd2, 32'h0000_00B2, 1, 0, 0, 5'd0, 32'h0};
    vecs[1]  = '{1, 5'd1, 32'h0000_00A1, 1, 5'd2, 32'h0000_00B2, 0, 1, 1, 5'd1, 32'h0000_00A1};
    vecs[2]  = '{1, 5'd1, 32'h0000_00A1, 1, 5'd2, 32'h0000_00B2, 1, 0, 1, 5'd2, 32'h0000_00B2};
    vecs[3]  = '{1, 5'd1, 32'h0000_00A1, 1, 5'd2, 32'h0000_00B2, 0, 1, 1, 5'd1, 32'h0000_00A1};
    vecs[4]  = '{1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd2, 32'h0000_00B2};
    vecs[5]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF};
    vecs[6]  = '{0, 5'd0, 32'h0, 1, 5'd0, 32'h0000_1234, 0, 1, 0, 5'd5, 32'hDEAD_BEEF};
    vecs[7]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd5, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 5'd0, 32'h0, 1, 5'd3, 32'h0000_CAFE, 0, 1, 0, 5'd5, 32'hDEAD_BEEF};
    vecs[9]  = '{1, 5'd4, 32'h4444_0004, 1, 5'd6, 32'h6666_0006, 1, 0, 1, 5'd3, 32'h0000_CAFE};
    vecs[10] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, 5'd4, 32'h4444_0004};
    vecs[11] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd4, 32'h4444_0004};

    drive_idle();
    model_reset();
    reset = 1'b1;
    alu_valid = 1'b1; ld_valid = 1'b1; alu_addr = 5'd3; ld_addr = 5'd4;
    @(negedge clk);
    @(negedge clk);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    release_reset();

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld,
           1'b0, 5'd0, 5'd0, 5'd0);
      chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
      chk($sformatf("v%0d_ld_ready", i), 64'(ld_ready), 64'(vecs[i].e_lr));
      chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(vecs[i].e_we));
      chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].e_wa));
      chk($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(vecs[i].e_wd));
    end

    // Scoreboard: set 7, write 7 retires it, then set coinciding with a write keeps it busy.
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    chk("sb_c1_busy", 64'(sb_busy_1), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    chk("sb_c2_busy", 64'(sb_busy_1), 64'(SB));
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    step(1, 5'd7, 32'h7777_0007, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    chk("sb_c4_busy", 64'(sb_busy_1), 64'(SB));
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    chk("sb_c5_busy", 64'(sb_busy_1), 64'(SB));
    chk("sb_c5_wr_addr", 64'(wr_addr), 64'd7);
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    chk("sb_c6_busy", 64'(sb_busy_1), 64'd0);
    step(1, 5'd7, 32'h7777_0017, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7);
    chk("sb_c8_wr_en", 64'(wr_en), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd0);
    chk("sb_c9_busy", 64'(sb_busy_1), 64'(SB));
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd7);
    chk("sb_x0_busy", 64'(sb_busy_2), 64'(SB));
    chk("sb_q0_busy", 64'(sb_busy_1), 64'd0);

    // Reset while a write is pending drops it immediately; a tie afterwards goes to ALU.
    step(1, 5'd9, 32'h9999_0009, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    chk("mid_wr_en_before", 64'(wr_en), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_wr_en", 64'(wr_en), 64'd0);
    chk("mid_wr_addr", 64'(wr_addr), 64'd0);
    chk("mid_alu_ready", 64'(alu_ready), 64'd0);
    release_reset();
    step(1, 5'd10, 32'hAAAA_000A, 1, 5'd11, 32'hBBBB_000B, 0, 5'd0, 5'd0, 5'd0);
    chk("post_rst_tie_alu", 64'(alu_ready), 64'd1);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           $urandom,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           $urandom,
           1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_soft_wb_arbiter.md
# riscv_soft_wb_arbiter

Writeback controller for the register file's single write port: it arbitrates between the ALU writeback and the load writeback, registers the winning write onto `wr_en`/`wr_addr`/`wr_data`, and discards writes to x0. It sits between the execute/memory stages and the register file. Optionally, it keeps a per-register busy scoreboard that the issue stage uses to hold back consumers of in-flight destinations.

## Interface
- `XPR_LEN`, default 32: data width of one architectural register.
- `NUM_REGS`, default 32: number of architectural registers; x0 is hardwired zero.
- `ADDR_W`, default 5: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_addr`  in  ADDR_W  ALU destination register.
- `alu_data`  in  XPR_LEN  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `ld_valid`  in  1  load writeback request.
- `ld_addr`  in  ADDR_W  load destination register.
- `ld_data`  in  XPR_LEN  load data.
- `ld_ready`  out  1  load request accepted this cycle.
- `wr_en`  out  1  register file write enable (registered).
- `wr_addr`  out  ADDR_W  register file write address (registered).
- `wr_data`  out  XPR_LEN  register file write data (registered).
- `sb_set`  in  1  issue stage marks `sb_set_addr` busy (scoreboard build only).
- `sb_set_addr`  in  ADDR_W  destination being issued.
- `sb_query_addr_1`, `sb_query_addr_2`  in  ADDR_W  source operands to check.
- `sb_busy_1`, `sb_busy_2`  out  1  queried register has a pending write.

## Operation
- **Acceptance.** A request is accepted when its `valid` and `ready` are both high in the same cycle. The register file always takes a write, so there is no backpressure from the output side.
- **Ready outputs.** `ready` is combinational and depends only on the arbitration result. A port that is requesting alone is granted immediately.
- **Round-robin arbitration.**
  - When both ports request, the port that was not granted last wins.
  - The `last_grant` register records the port of every accepted request.
  - On reset, `last_grant` = load, so ALU wins the first tie.
- **Writes to x0.** An accepted request with `addr` == 0 is consumed: `ready` is high and `last_grant` updates. It produces `wr_en` = 0 the next cycle and has no scoreboard effect.
- **Output register.** `wr_en`, `wr_addr` and `wr_data` load from the winner on every edge. When nothing is accepted, `wr_en` returns to 0. `wr_addr` and `wr_data` hold their last values while `wr_en` = 0.
- **Scoreboard.**
  - A `NUM_REGS`-bit busy vector.
  - `sb_set` with a nonzero address sets that bit at the edge.
  - A bit clears at the edge where `wr_en` = 1 and `wr_addr` selects it, i.e. the same edge that updates the register file.
  - If set and clear hit the same address in the same cycle, set wins (a newer producer is in flight).
  - Bit 0 is constant 0.
  - `sb_busy_n` is a combinational read of the vector.

## Timing
- **Reset values.** `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, busy vector all 0, `last_grant` = load.
  - Reset is asynchronous. Asserting it mid-operation drops any registered write immediately.
  - Requests presented during reset are not accepted: `alu_ready` = `ld_ready` = 0 while `reset` = 1.
- **Write latency.** Acceptance in cycle N gives `wr_en` in cycle N+1. The register file is written at the end of cycle N+1.
- **Scoreboard timing.**
  - `sb_set` in cycle N makes `sb_busy` = 1 from cycle N+1.
  - The clear edge is the end of the `wr_en` cycle, so `sb_busy` = 0 from cycle N+2 relative to acceptance.
- **Throughput.** One write per cycle. When both ports request continuously, they alternate.

## Configuration
- **`RISCV_SOFT_WB_SCOREBOARD_EN` defined:** the busy vector and its set/clear/query logic are compiled in, behaving as above.
- **`RISCV_SOFT_WB_SCOREBOARD_EN` undefined:**
  - The busy vector and its logic are absent.
  - `sb_busy_1` and `sb_busy_2` are tied to 0.
  - The `sb_*` inputs remain on the port list and are ignored.
  - Arbitration and writeback are unchanged.

## Test plan
- **Reset defaults:** assert `reset` mid-stream with a write pending -> `wr_en` = 0 immediately; after release, a tie grants ALU first.
- **Single requester:** `alu_valid`, addr 5, data 0xDEADBEEF in cycle 1 -> `alu_ready` = 1 in cycle 1; `wr_en` = 1, `wr_addr` = 5, `wr_data` = 0xDEADBEEF in cycle 2; `wr_en` = 0 in cycle 3.
- **Contention:** both ports valid for 4 cycles (ALU addr 1, load addr 2) -> grants alternate ALU, load, ALU, load; writes appear one cycle later; neither port is starved.
- **x0 drop:** load addr 0, data 0x1234 -> `ld_ready` = 1; next cycle `wr_en` = 0; `sb_busy` for addr 0 stays 0.
- **Scoreboard:** `sb_set` addr 7 in cycle 1 -> `sb_busy_1` (query 7) = 1 from cycle 2. ALU write to 7 accepted in cycle 4 -> busy = 1 in cycle 5, 0 in cycle 6. `sb_set` addr 7 in the same cycle as `wr_en` to 7 -> stays busy.
- **Build without `RISCV_SOFT_WB_SCOREBOARD_EN`:** repeat the scoreboard scenario -> `sb_busy_1` = `sb_busy_2` = 0 throughout; writes are identical to the scoreboard build.
